jtag_tap_ctrl: RTL and testbench

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_tap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with IR, BYPASS, optional IDCODE and one user data register.
// Define JTAG_TAP_IDCODE_EN to include the IDCODE register and make IDCODE_OP the reset instruction.
module jtag_tap_ctrl #(
  parameter int                  IR_WIDTH  = 4,
  parameter int                  DR_WIDTH  = 32,
  parameter logic [31:0]         IDCODE    = 32'h0000_0001,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP = 'h1,
  parameter logic [IR_WIDTH-1:0] USER_OP   = 'h2
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  input  logic [DR_WIDTH-1:0] user_dr_in,
  output logic [DR_WIDTH-1:0] user_dr_out,
  output logic                user_update,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_value
);

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } state_t;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH:0]   ir_cat;
  logic [DR_WIDTH-1:0] user_sr;
  logic [DR_WIDTH:0]   user_cat;
  logic                byp_sr;
  logic                id_tdo;
  logic                dr_tdo;
  logic                sel_id;
  logic                sel_user;

  assign tap_state = state;
  assign ir_cat    = {tdi, ir_sr};
  assign user_cat  = {tdi, user_sr};

`ifdef JTAG_TAP_IDCODE_EN
  localparam bit                  ID_EN    = 1'b1;
  localparam logic [IR_WIDTH-1:0] IR_RESET = IDCODE_OP;

  logic [31:0] id_sr;

  // IDCODE register: bit 0 is forced to 1 as the standard requires
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      id_sr <= '0;
    end else if (sel_id) begin
      if (state == CAP_DR)
        id_sr <= {IDCODE[31:1], 1'b1};
      else if (state == SH_DR)
        id_sr <= {tdi, id_sr[31:1]};
    end
  end

  assign id_tdo = id_sr[0];
`else
  localparam bit                  ID_EN    = 1'b0;
  localparam logic [IR_WIDTH-1:0] IR_RESET = '1;

  assign id_tdo = 1'b0;
`endif

  assign sel_id   = ID_EN && (ir_value == IDCODE_OP);
  assign sel_user = !sel_id && (ir_value == USER_OP);
  assign dr_tdo   = sel_id ? id_tdo : (sel_user ? user_sr[0] : byp_sr);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state <= TLR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      TLR:      state_nxt = tms ? TLR      : RTI;
      RTI:      state_nxt = tms ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms ? EX1_DR   : SH_DR;
      SH_DR:    state_nxt = tms ? EX1_DR   : SH_DR;
      EX1_DR:   state_nxt = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_nxt = tms ? UPD_DR   : SH_DR;
      UPD_DR:   state_nxt = tms ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms ? EX1_IR   : SH_IR;
      SH_IR:    state_nxt = tms ? EX1_IR   : SH_IR;
      EX1_IR:   state_nxt = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_nxt = tms ? UPD_IR   : SH_IR;
      UPD_IR:   state_nxt = tms ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  // Capture and shift on the rising edge; all other states hold the registers
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_sr   <= '0;
      user_sr <= '0;
      byp_sr  <= 1'b0;
    end else begin
      case (state)
        CAP_IR: ir_sr <= IR_CAPTURE;
        SH_IR:  ir_sr <= ir_cat[IR_WIDTH:1];
        CAP_DR: begin
          if (sel_user)     user_sr <= user_dr_in;
          else if (!sel_id) byp_sr  <= 1'b0;
        end
        SH_DR: begin
          if (sel_user)     user_sr <= user_cat[DR_WIDTH:1];
          else if (!sel_id) byp_sr  <= tdi;
        end
        default: ;
      endcase
    end
  end

  // Falling-edge side: tdo, update latches and instruction reset in TLR
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo         <= 1'b0;
      tdo_en      <= 1'b0;
      user_dr_out <= '0;
      user_update <= 1'b0;
      ir_value    <= IR_RESET;
    end else begin
      tdo_en      <= (state == SH_DR) || (state == SH_IR);
      tdo         <= (state == SH_IR) ? ir_sr[0] : ((state == SH_DR) ? dr_tdo : 1'b0);
      user_update <= (state == UPD_DR) && sel_user;
      if ((state == UPD_DR) && sel_user)
        user_dr_out <= user_sr;
      if (state == UPD_IR)
        ir_value <= ir_sr;
      else if (state == TLR)
        ir_value <= IR_RESET;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl (IR_WIDTH=4, DR_WIDTH=8, IDCODE=32'h1234_5679).
// Expectations follow JTAG_TAP_IDCODE_EN so the bench suits either build.
module tb_jtag_tap_ctrl;

  logic       tck = 1'b0;
  logic       trst_n;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic [7:0] user_dr_in;
  logic [7:0] user_dr_out;
  logic       user_update;
  logic [3:0] tap_state;
  logic [3:0] ir_value;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_pulses = 0;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0]  IR_RST    = 4'h1;
  localparam logic [31:0] ID_STREAM = 32'h1234_5679;
  localparam logic [31:0] ID_OP_EXP = 32'h1234_5679;
`else
  localparam logic [3:0]  IR_RST    = 4'hF;
  localparam logic [31:0] ID_STREAM = 32'h0000_0000;
  localparam logic [31:0] ID_OP_EXP = 32'h0000_0006;
`endif

  jtag_tap_ctrl #(
    .IR_WIDTH (4),
    .DR_WIDTH (8),
    .IDCODE   (32'h1234_5679),
    .IDCODE_OP(4'h1),
    .USER_OP  (4'h2)
  ) dut (
    .tck        (tck),
    .trst_n     (trst_n),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .user_dr_in (user_dr_in),
    .user_dr_out(user_dr_out),
    .user_update(user_update),
    .tap_state  (tap_state),
    .ir_value   (ir_value)
  );

  always #5 tck = ~tck;

  always @(posedge user_update) upd_pulses <= upd_pulses + 1;

  // tdo is sampled before the rising edge that shifts it out
  task automatic step(input logic tms_v, input logic tdi_v, output logic tdo_v);
    tms   = tms_v;
    tdi   = tdi_v;
    tdo_v = tdo;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  // From RTI: scan an IR value, return captured bits, end in RTI
  task automatic load_ir(input logic [3:0] op, output logic [3:0] cap);
    logic b;
    step(1'b1, 1'b0, b);
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, op[i], b);
      cap[i] = b;
    end
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
  endtask

  // From RTI: scan n DR bits, return tdo stream, end in Update-DR
  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic b;
    dout = '0;
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], b);
      dout[i] = b;
    end
    step(1'b1, 1'b0, b);
  endtask

  task automatic test_reset;
    trst_n = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    user_dr_in = 8'h3C;
    @(negedge tck);
    #1;
    n_checks++;
    if (tap_state !== 4'hF) begin n_fail++; $display("FAIL reset_state: got %h expected %h", tap_state, 4'hF); end
    n_checks++;
    if (ir_value !== IR_RST) begin n_fail++; $display("FAIL reset_ir: got %h expected %h", ir_value, IR_RST); end
    n_checks++;
    if ({tdo, tdo_en, user_update} !== 3'b000) begin n_fail++; $display("FAIL reset_outs: got %b expected 000", {tdo, tdo_en, user_update}); end
    n_checks++;
    if (user_dr_out !== 8'h00) begin n_fail++; $display("FAIL reset_user_dr: got %h expected 00", user_dr_out); end
    trst_n = 1'b1;
  endtask

  task automatic test_idcode;
    logic b;
    logic [31:0] dout;
    step(1'b0, 1'b0, b);
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    n_checks++;
    if (tap_state !== 4'h2) begin n_fail++; $display("FAIL shift_dr_state: got %h expected 2", tap_state); end
    n_checks++;
    if (tdo_en !== 1'b1) begin n_fail++; $display("FAIL shift_tdo_en: got %b expected 1", tdo_en); end
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'b0, b);
      dout[i] = b;
    end
    n_checks++;
    if (dout !== ID_STREAM) begin n_fail++; $display("FAIL idcode_stream: got %h expected %h", dout, ID_STREAM); end
    n_checks++;
    if ({tap_state, tdo_en, tdo} !== {4'h1, 2'b00}) begin
      n_fail++; $display("FAIL exit1_outs: got %h/%b%b expected 1/00", tap_state, tdo_en, tdo);
    end
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    n_checks++;
    if (tap_state !== 4'hC) begin n_fail++; $display("FAIL back_to_rti: got %h expected C", tap_state); end
  endtask

  task automatic test_user;
    logic b;
    logic [3:0] cap;
    logic [31:0] dout;
    load_ir(4'h2, cap);
    n_checks++;
    if (cap !== 4'b0001) begin n_fail++; $display("FAIL ir_capture: got %b expected 0001", cap); end
    n_checks++;
    if (ir_value !== 4'h2) begin n_fail++; $display("FAIL ir_user: got %h expected 2", ir_value); end
    user_dr_in = 8'h3C;
    scan_dr(32'h0000_00A5, 8, dout);
    n_checks++;
    if (dout[7:0] !== 8'h3C) begin n_fail++; $display("FAIL user_capture: got %h expected 3C", dout[7:0]); end
    n_checks++;
    if (user_dr_out !== 8'hA5) begin n_fail++; $display("FAIL user_dr_out: got %h expected A5", user_dr_out); end
    n_checks++;
    if (user_update !== 1'b1) begin n_fail++; $display("FAIL update_high: got %b expected 1", user_update); end
    step(1'b0, 1'b0, b);
    n_checks++;
    if (user_update !== 1'b0) begin n_fail++; $display("FAIL update_one_tck: got %b expected 0", user_update); end
  endtask

  task automatic test_idcode_op;
    logic [3:0] cap;
    logic [31:0] dout;
    logic b;
    load_ir(4'h1, cap);
    scan_dr(32'h0000_0003, 32, dout);
    step(1'b0, 1'b0, b);
    n_checks++;
    if (dout !== ID_OP_EXP) begin n_fail++; $display("FAIL idcode_op_scan: got %h expected %h", dout, ID_OP_EXP); end
  endtask

  task automatic test_bypass;
    logic [3:0] cap;
    logic [31:0] dout;
    logic b;
    load_ir(4'hF, cap);
    n_checks++;
    if (ir_value !== 4'hF) begin n_fail++; $display("FAIL ir_bypass: got %h expected F", ir_value); end
    scan_dr(32'h0000_000D, 4, dout);
    n_checks++;
    if (dout[3:0] !== 4'hA) begin n_fail++; $display("FAIL bypass_echo: got %b expected 1010", dout[3:0]); end
    n_checks++;
    if (user_update !== 1'b0) begin n_fail++; $display("FAIL bypass_no_update: got %b expected 0", user_update); end
    step(1'b0, 1'b0, b);
  endtask

  task automatic test_tlr_from_pause;
    logic b;
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b1, b);
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    n_checks++;
    if (tap_state !== 4'h3) begin n_fail++; $display("FAIL pause_dr_state: got %h expected 3", tap_state); end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b);
    n_checks++;
    if (tap_state !== 4'hF) begin n_fail++; $display("FAIL tms_tlr_state: got %h expected F", tap_state); end
    n_checks++;
    if (ir_value !== IR_RST) begin n_fail++; $display("FAIL tms_tlr_ir: got %h expected %h", ir_value, IR_RST); end
    n_checks++;
    if (user_dr_out !== 8'hA5) begin n_fail++; $display("FAIL tms_tlr_user_dr: got %h expected A5", user_dr_out); end
  endtask

  task automatic test_trst_mid_shift;
    logic b;
    logic [3:0] cap;
    int pulses_before;
    step(1'b0, 1'b0, b);
    load_ir(4'h2, cap);
    pulses_before = upd_pulses;
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, b);
    trst_n = 1'b0;
    #1;
    n_checks++;
    if (tap_state !== 4'hF) begin n_fail++; $display("FAIL trst_state: got %h expected F", tap_state); end
    n_checks++;
    if (user_dr_out !== 8'h00) begin n_fail++; $display("FAIL trst_user_dr: got %h expected 00", user_dr_out); end
    n_checks++;
    if ({tdo, tdo_en} !== 2'b00) begin n_fail++; $display("FAIL trst_tdo: got %b expected 00", {tdo, tdo_en}); end
    n_checks++;
    if (ir_value !== IR_RST) begin n_fail++; $display("FAIL trst_ir: got %h expected %h", ir_value, IR_RST); end
    @(negedge tck);
    #1;
    step(1'b1, 1'b0, b);
    step(1'b1, 1'b0, b);
    trst_n = 1'b1;
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    n_checks++;
    if (upd_pulses !== pulses_before) begin n_fail++; $display("FAIL trst_no_update: got %0d pulses expected %0d", upd_pulses, pulses_before); end
    n_checks++;
    if (tap_state !== 4'hC) begin n_fail++; $display("FAIL trst_recover_rti: got %h expected C", tap_state); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_user();
    test_idcode_op();
    test_bypass();
    test_tlr_from_pause();
    test_trst_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
